f36m_mult: RTL
==============

Name: f36m_mult

Overview:
- Multiplier for GF(3^{6m}) = GF(3^{3m})[y]/(y^2+1), with m=97.
- Sits directly downstream of f33m_mult: it instantiates exactly one f33m_mult, sequences it three times using Karatsuba, then combines the partial products with GF(3^m) trit-wise add/subtract.
- Consumed by the final-exponentiation and Miller-loop datapaths, which need full GF(3^{6m}) products.

Parameters:
- None. Widths come from the shared include: `W3`=581 (one GF(3^{3m}) element), `W6`=1163 (one GF(3^{6m}) element).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high. Clears state and, on deassertion, starts a multiplication with the operands sampled in the reset cycle.
- a  in  `W6`+1  operand {a1,a0}; a1=[`W6`:`W3`+1], a0=[`W3`:0]. Each half is {x2,x1,x0} of 194-bit GF(3^m) words.
- b  in  `W6`+1  operand {b1,b0}, same layout.
- c  out  `W6`+1  product {c1,c0}, registered.
- done  out  1  high once c is valid; stays high until the next reset.

Behaviour:
- Trit encoding is 2 bits per trit: 00=0, 01=1, 10=2. 11 is never generated.
  - add: per-trit mod 3.
  - negate: swap the two bits of each trit.
  - sub: add of the negated operand.
- Math:
  - t0=a0*b0, t1=a1*b1, t2=(a0+a1)*(b0+b1).
  - c0=t0-t1 (because y^2=-1).
  - c1=t2-t0-t1.
- Reset cycle (reset=1 at an edge):
  - a,b latched into internal registers.
  - c<=0, done<=0, state<=S_IDLE0.
  - Inner f33m_mult held in reset.
  - Inputs are ignored outside reset cycles.
- FSM states: S_IDLE0, S_M0, S_M1, S_M2, S_FIN, S_DONE.
  - S_IDLE0 -> S_M0: inner operands = (a0,b0); inner reset pulsed high for exactly 1 cycle.
  - S_M0: wait for inner done=1, sampled no earlier than the 2nd cycle after the pulse. Then t0<=inner c, operands <= (a1,b1), pulse inner reset, go to S_M1.
  - S_M1: on inner done, t1<=inner c; operands <= (a0+a1, b0+b1); pulse; go to S_M2.
  - S_M2: on inner done, t2<=inner c; go to S_FIN.
  - S_FIN: c<={t2-t0-t1, t0-t1} registered; done<=1; go to S_DONE.
  - S_DONE: hold c and done until reset.
- Inner operand mux is registered. Operands are stable from the pulse cycle until the inner done.
- Latency: reset falling edge to done rising = 3*(Lm+2)+2 cycles, where Lm is the fixed f33m_mult latency. Latency is data-independent.
- Reset mid-operation: aborts immediately, with identical effect to a fresh reset. No stale t0/t1/t2 may leak into the new result. done stays 0 until the new result is written.
- Reset held several cycles: operands sampled in the last reset cycle win. Computation starts after deassertion.
- Inner done stuck high from the previous sub-multiply must not be mistaken for completion. The 1-cycle blanking after each pulse is mandatory.
- No 11 trit codes may appear on c for legal inputs.

Test Plan:
- a={0,ONE} (ONE: x0=194'h1, x1=x2=0), b=random legal value -> c==b, done rises exactly 3*(Lm+2)+2 cycles after reset falls.
- a={ONE,0} (a=y), b={b1,b0} with b0 x0=194'h1, b1 x0=194'h2, all other words 0 -> c1 x0=194'h1, c0 x0=194'h1, all other words 0.
- a=b={ONE,0} (y*y) -> c0 x0=194'h2 (i.e. -1), all other 1162 bits 0.
- a=0, b=all-trits-2 (every pair 10) -> c==0, done=1. Then c and done stay stable for 50 further cycles with no reset.
- Random a,b: assert reset again during S_M1 with new operands a',b' -> c equals the software-model product a'*b', never a*b. Repeat for 100 random pairs against the golden model; also check no 11 trit pairs appear on c.

Source files
------------

// File: rtl/f36m_mult.sv
// f36m_mult: GF(3^{6m}) multiplier, m = 97, GF(3^{6m}) = GF(3^{3m})[y]/(y^2+1).
// Karatsuba over one shared f33m_mult, run three times:
//   t0 = a0*b0, t1 = a1*b1, t2 = (a0+a1)*(b0+b1), c0 = t0 - t1, c1 = t2 - t0 - t1.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high; latches a/b and starts a product on release
//   a, b  : operands {x1, x0}, each half {w2, w1, w0} of 194-bit GF(3^m) words
//   c     : registered product {c1, c0}
//   done  : high once c is valid, held until the next reset
// Trit code: 00 = 0, 01 = 1, 10 = 2 (low bit of each pair is the "1" flag).
//
// f33m_mult (same file): GF(3^{3m}) = GF(3^m)[y]/(y^3 - y - 1) multiplier,
// GF(3^m) = GF(3)[x]/(x^97 + x^12 + 2). Trit-serial Horner over b, fixed
// latency of 98 cycles from its reset edge to done.

`ifndef W3
`define W3 581
`endif
`ifndef W6
`define W6 1163
`endif

module f36m_mult (
    input  logic          clk,
    input  logic          reset,
    input  logic [`W6:0]  a,
    input  logic [`W6:0]  b,
    output logic [`W6:0]  c,
    output logic          done
);

    localparam logic [`W3:0] EVN = {291{2'b01}};

    typedef enum logic [2:0] {S_IDLE0, S_M0, S_M1, S_M2, S_FIN, S_DONE} state_t;

    // Bit-sliced trit add: lo/hi planes gathered onto the even bit positions.
    function automatic logic [`W3:0] e_add(input logic [`W3:0] x, input logic [`W3:0] y);
        logic [`W3:0] x0, x1, y0, y1, t, z0, z1;
        x0 = x & EVN;
        x1 = (x >> 1) & EVN;
        y0 = y & EVN;
        y1 = (y >> 1) & EVN;
        t  = (x1 | y0) ^ (x0 | y1);
        z1 = (x0 | y0) ^ t;
        z0 = (x1 | y1) ^ t;
        return (z1 << 1) | z0;
    endfunction

    function automatic logic [`W3:0] e_neg(input logic [`W3:0] x);
        return ((x >> 1) & EVN) | ((x & EVN) << 1);
    endfunction

    state_t        state_q;
    logic [`W6:0]  a_q, b_q;
    logic [`W3:0]  opa_q, opb_q;
    logic [`W3:0]  t0_q, t1_q, t2_q;
    logic [`W6:0]  c_q;
    logic          done_q;
    logic          irst_q;

    logic          inner_rst;
    logic [`W3:0]  inner_c;
    logic          inner_done;
    logic          sub_done;
    logic [`W3:0]  sum_a, sum_b, c0_d, c1_d;

    // Inner unit is held in reset whenever the outer one is.
    assign inner_rst = reset | irst_q;

    // The cycle right after a pulse still shows the previous sub-product's done.
    assign sub_done = inner_done & ~irst_q;

    assign sum_a = e_add(a_q[`W3:0], a_q[`W6:`W3+1]);
    assign sum_b = e_add(b_q[`W3:0], b_q[`W6:`W3+1]);
    assign c0_d  = e_add(t0_q, e_neg(t1_q));
    assign c1_d  = e_add(e_add(t2_q, e_neg(t0_q)), e_neg(t1_q));

    f33m_mult u_f33m (
        .clk   (clk),
        .reset (inner_rst),
        .a     (opa_q),
        .b     (opb_q),
        .c     (inner_c),
        .done  (inner_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= a;
            b_q     <= b;
            opa_q   <= '0;
            opb_q   <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            irst_q  <= 1'b0;
            state_q <= S_IDLE0;
        end else begin
            irst_q <= 1'b0;
            case (state_q)
                S_IDLE0: begin
                    opa_q   <= a_q[`W3:0];
                    opb_q   <= b_q[`W3:0];
                    irst_q  <= 1'b1;
                    state_q <= S_M0;
                end
                S_M0: begin
                    if (sub_done) begin
                        t0_q    <= inner_c;
                        opa_q   <= a_q[`W6:`W3+1];
                        opb_q   <= b_q[`W6:`W3+1];
                        irst_q  <= 1'b1;
                        state_q <= S_M1;
                    end
                end
                S_M1: begin
                    if (sub_done) begin
                        t1_q    <= inner_c;
                        opa_q   <= sum_a;
                        opb_q   <= sum_b;
                        irst_q  <= 1'b1;
                        state_q <= S_M2;
                    end
                end
                S_M2: begin
                    if (sub_done) begin
                        t2_q    <= inner_c;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    c_q     <= {c1_d, c0_d};
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE0;
                end
            endcase
        end
    end

    assign c    = c_q;
    assign done = done_q;

endmodule

module f33m_mult (
    input  logic          clk,
    input  logic          reset,
    input  logic [`W3:0]  a,
    input  logic [`W3:0]  b,
    output logic [`W3:0]  c,
    output logic          done
);

    localparam int unsigned M  = 97;
    localparam int unsigned WW = 194;
    localparam logic [WW-1:0] EVN = {97{2'b01}};

    function automatic logic [WW-1:0] w_add(input logic [WW-1:0] x, input logic [WW-1:0] y);
        logic [WW-1:0] x0, x1, y0, y1, t, z0, z1;
        x0 = x & EVN;
        x1 = (x >> 1) & EVN;
        y0 = y & EVN;
        y1 = (y >> 1) & EVN;
        t  = (x1 | y0) ^ (x0 | y1);
        z1 = (x0 | y0) ^ t;
        z0 = (x1 | y1) ^ t;
        return (z1 << 1) | z0;
    endfunction

    function automatic logic [WW-1:0] w_neg(input logic [WW-1:0] x);
        return ((x >> 1) & EVN) | ((x & EVN) << 1);
    endfunction

    function automatic logic [WW-1:0] w_scale(input logic [WW-1:0] v, input logic [1:0] t);
        logic [WW-1:0] r;
        case (t)
            2'b01:   r = v;
            2'b10:   r = w_neg(v);
            default: r = '0;
        endcase
        return r;
    endfunction

    // v*x mod (x^97 + x^12 + 2): the trit shifted out as t folds back as t*(2x^12 + 1).
    function automatic logic [WW-1:0] w_mulx(input logic [WW-1:0] v);
        logic [1:0]    t;
        logic [WW-1:0] f;
        t       = v[WW-1:WW-2];
        f       = '0;
        f[1:0]  = t;
        f[25:24] = {t[0], t[1]};
        return w_add({v[WW-3:0], 2'b00}, f);
    endfunction

    logic [2:0][WW-1:0] a_q, b_q, b_d;
    logic [4:0][WW-1:0] p_q, p_d;
    logic [6:0]         cnt_q;
    logic [`W3:0]       c_q, c_d;
    logic               done_q;

    // Horner step over the current top trit of each b word; all five
    // y-power partial sums advance together.
    always_comb begin
        p_d = '0;
        b_d = '0;
        for (int unsigned k = 0; k < 5; k++) begin
            p_d[k] = w_mulx(p_q[k]);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            for (int unsigned j = 0; j < 3; j++) begin
                p_d[i+j] = w_add(p_d[i+j], w_scale(a_q[i], b_q[j][WW-1:WW-2]));
            end
        end
        for (int unsigned j = 0; j < 3; j++) begin
            b_d[j] = {b_q[j][WW-3:0], 2'b00};
        end
    end

    // Fold y^3 = y + 1 and y^4 = y^2 + y.
    assign c_d = {w_add(p_q[2], p_q[4]),
                  w_add(w_add(p_q[1], p_q[3]), p_q[4]),
                  w_add(p_q[0], p_q[3])};

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= a;
            b_q    <= b;
            p_q    <= '0;
            cnt_q  <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else if (cnt_q < 7'(M)) begin
            p_q   <= p_d;
            b_q   <= b_d;
            cnt_q <= cnt_q + 7'd1;
        end else if (!done_q) begin
            c_q    <= c_d;
            done_q <= 1'b1;
        end
    end

    assign c    = c_q;
    assign done = done_q;

endmodule
